// File: rtl/tree_result_serializer_if.sv
// Result-word stream from the adder-tree serializer to its consumer.
// Valid/ready handshake; a word moves on an edge where both are high.
interface tree_result_serializer_if #(
  parameter int MAC_BW = 8
);
  logic                  out_valid;
  logic                  out_ready;
  logic [2*MAC_BW-1:0]   out_data;
  logic [3:0]            out_idx;
  logic                  out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/tree_result_serializer.sv
// Captures one adder-tree level (16/4/1 words) mode+1 cycles after start and streams it out.
// Words hold while out_ready is low; back-to-back words with no bubble when ready stays high.
module tree_result_serializer #(
  parameter int MAC_BW = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [2*MAC_BW-1:0]   in_l1 [16],
  input  logic [2*MAC_BW-1:0]   in_l2 [4],
  input  logic [2*MAC_BW-1:0]   in_l3,
  tree_result_serializer_if.master res,
  output logic                  busy,
  output logic                  err
);
  localparam int W = 2 * MAC_BW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    lvl;
  logic [1:0]    cnt;
  logic [W-1:0]  buffer [16];
  logic [3:0]    last_idx;
  logic [3:0]    idx_nxt;
  logic [W-1:0]  first_word;
  logic          capture;
  logic          xfer;

  assign capture = (state == WAIT) && (cnt == 2'd1);
  assign xfer    = (state == SEND) && res.out_valid && res.out_ready;
  assign idx_nxt = res.out_idx + 4'd1;

  always_comb begin
    last_idx   = 4'd0;
    first_word = in_l3;
    case (lvl)
      2'd0: begin
        last_idx   = 4'd15;
        first_word = in_l1[0];
      end
      2'd1: begin
        last_idx   = 4'd3;
        first_word = in_l2[0];
      end
      default: begin
        last_idx   = 4'd0;
        first_word = in_l3;
      end
    endcase
  end

  // Buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      case (lvl)
        2'd0: for (int i = 0; i < 16; i++) buffer[i] <= in_l1[i];
        2'd1: for (int i = 0; i < 4; i++)  buffer[i] <= in_l2[i];
        default: buffer[0] <= in_l3;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      lvl           <= 2'd0;
      cnt           <= 2'd0;
      busy          <= 1'b0;
      err           <= 1'b0;
      res.out_valid <= 1'b0;
      res.out_data  <= '0;
      res.out_idx   <= 4'd0;
      res.out_last  <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (mode == 2'd3) begin
              err <= 1'b1;
            end else begin
              lvl   <= mode;
              cnt   <= mode + 2'd1;
              busy  <= 1'b1;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          err <= start;
          if (capture) begin
            // Word 0 goes straight from the tree so SEND starts with valid data.
            cnt           <= 2'd0;
            state         <= SEND;
            res.out_valid <= 1'b1;
            res.out_data  <= first_word;
            res.out_idx   <= 4'd0;
            res.out_last  <= (last_idx == 4'd0);
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        SEND: begin
          err <= start;
          if (xfer) begin
            if (res.out_last) begin
              state         <= IDLE;
              busy          <= 1'b0;
              res.out_valid <= 1'b0;
              res.out_data  <= '0;
              res.out_idx   <= 4'd0;
              res.out_last  <= 1'b0;
            end else begin
              res.out_idx  <= idx_nxt;
              res.out_data <= buffer[idx_nxt];
              res.out_last <= (idx_nxt == last_idx);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tree_result_serializer.sv
// Bench for tree_result_serializer: directed bursts plus random traffic against a queue-based model.
module tb_tree_result_serializer;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] in_l1 [16];
  logic [15:0] in_l2 [4];
  logic [15:0] in_l3;
  logic        busy;
  logic        err;

  tree_result_serializer_if #(.MAC_BW(8)) res_if ();

  tree_result_serializer #(.MAC_BW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .in_l1 (in_l1),
    .in_l2 (in_l2),
    .in_l3 (in_l3),
    .res   (res_if),
    .busy  (busy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: an accepted start schedules a snapshot k edges later,
  // the snapshot becomes a queue of words, and each handshake pops one.
  logic        m_busy;
  logic        m_send;
  logic        m_err;
  int          m_wait;
  int          m_lvl;
  int          m_sent;
  logic [15:0] exp_q [$];

  logic [15:0] got_q [$];
  int          cyc_q [$];
  int          cyc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_busy = 1'b0;
    m_send = 1'b0;
    m_err  = 1'b0;
    m_wait = 0;
    m_lvl  = 0;
    m_sent = 0;
    exp_q.delete();
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 16; i++) in_l1[i] = 16'($urandom);
    for (int i = 0; i < 4; i++)  in_l2[i] = 16'($urandom);
    in_l3 = 16'($urandom);
  endtask

  // Called with clk low: check current outputs, advance the model over the next edge, then clock.
  task automatic step();
    logic [15:0] e_data;
    e_data = 16'h0;
    if (m_send && exp_q.size() > 0) e_data = exp_q[0];
    check_eq("valid", res_if.out_valid, m_send);
    check_eq("data",  res_if.out_data, e_data);
    check_eq("idx",   res_if.out_idx, m_send ? m_sent : 0);
    check_eq("last",  res_if.out_last, m_send && exp_q.size() == 1);
    check_eq("busy",  busy, m_busy);
    check_eq("err",   err, m_err);
    if (res_if.out_valid && res_if.out_ready) begin
      got_q.push_back(res_if.out_data);
      cyc_q.push_back(cyc);
    end

    m_err = start && (m_busy || mode == 2'd3);
    if (m_send) begin
      if (res_if.out_ready) begin
        void'(exp_q.pop_front());
        m_sent++;
        if (exp_q.size() == 0) begin
          m_send = 1'b0;
          m_busy = 1'b0;
        end
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        if (m_lvl == 0)      for (int i = 0; i < 16; i++) exp_q.push_back(in_l1[i]);
        else if (m_lvl == 1) for (int i = 0; i < 4; i++)  exp_q.push_back(in_l2[i]);
        else                 exp_q.push_back(in_l3);
        m_send = 1'b1;
        m_sent = 0;
      end
    end else if (start && mode != 2'd3) begin
      m_busy = 1'b1;
      m_wait = int'(mode) + 1;
      m_lvl  = int'(mode);
    end

    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int limit, input logic scramble);
    int n;
    n = 0;
    start = 1'b0;
    while ((m_busy || busy) && n < limit) begin
      if (scramble && m_send) rand_inputs();
      step();
      n++;
    end
    check_eq("drain_timeout", n >= limit, 0);
  endtask

  initial begin
    cyc    = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    mode   = 2'd0;
    res_if.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) in_l1[i] = 16'h0;
    for (int i = 0; i < 4; i++)  in_l2[i] = 16'h0;
    in_l3 = 16'h0;
    model_clear();

    @(negedge clk);
    check_eq("rst_valid", res_if.out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // L1 burst with constant ready, inputs scrambled after capture
    for (int i = 0; i < 16; i++) in_l1[i] = 16'h0100 + 16'(i);
    res_if.out_ready = 1'b1;
    got_q.delete(); cyc_q.delete();
    start = 1'b1; mode = 2'd0;
    step();
    start = 1'b0;
    step();
    drain(60, 1'b1);
    check_eq("l1_count", got_q.size(), 16);
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      check_eq("l1_word", got_q[i], 16'h0100 + 16'(i));
    if (cyc_q.size() == 16) check_eq("l1_no_bubble", cyc_q[15] - cyc_q[0], 15);
    check_eq("l1_busy_after", busy, 0);

    // L2 burst with ready pattern 1,0,0 repeating
    in_l2[0] = 16'h0001; in_l2[1] = 16'h0002; in_l2[2] = 16'h0003; in_l2[3] = 16'h0004;
    got_q.delete(); cyc_q.delete();
    start = 1'b1; mode = 2'd1;
    res_if.out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int p = 0; p < 60 && (m_busy || busy); p++) begin
      res_if.out_ready = (p % 3 == 0);
      if (m_send) rand_inputs();
      step();
    end
    check_eq("l2_done", busy, 0);
    check_eq("l2_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check_eq("l2_word", got_q[i], 16'(i + 1));

    // L3 latency: input becomes valid only from E2
    res_if.out_ready = 1'b0;
    in_l3 = 16'h1111;
    start = 1'b1; mode = 2'd2;
    step();                 // E0
    start = 1'b0;
    step();                 // E1
    in_l3 = 16'hBEEF;
    step();                 // E2
    check_eq("l3_not_yet", res_if.out_valid, 0);
    step();                 // E3 capture
    check_eq("l3_valid", res_if.out_valid, 1);
    check_eq("l3_data", res_if.out_data, 16'hBEEF);
    check_eq("l3_idx", res_if.out_idx, 0);
    check_eq("l3_last", res_if.out_last, 1);
    // start coinciding with the only (final) transfer is rejected
    in_l3 = 16'h0;
    res_if.out_ready = 1'b1;
    start = 1'b1; mode = 2'd2;
    step();
    start = 1'b0;
    check_eq("final_start_err", err, 1);
    check_eq("final_start_busy", busy, 0);
    step();

    // Reserved mode rejected in IDLE
    start = 1'b1; mode = 2'd3;
    step();
    start = 1'b0;
    check_eq("mode3_err", err, 1);
    check_eq("mode3_busy", busy, 0);
    step();
    check_eq("mode3_err_once", err, 0);

    // Start during SEND is rejected and the burst is untouched
    for (int i = 0; i < 16; i++) in_l1[i] = 16'h0A00 + 16'(i);
    got_q.delete(); cyc_q.delete();
    start = 1'b1; mode = 2'd0;
    step();
    start = 1'b0;
    step();
    step();
    start = 1'b1; mode = 2'd1;
    step();
    start = 1'b0;
    check_eq("send_start_err", err, 1);
    step();
    check_eq("send_start_err_once", err, 0);
    drain(60, 1'b1);
    check_eq("rej_count", got_q.size(), 16);
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      check_eq("rej_word", got_q[i], 16'h0A00 + 16'(i));

    // Reset after the 5th word of an L1 burst
    for (int i = 0; i < 16; i++) in_l1[i] = 16'h0200 + 16'(i);
    got_q.delete(); cyc_q.delete();
    start = 1'b1; mode = 2'd0;
    step();
    start = 1'b0;
    begin
      int n;
      n = 0;
      while (got_q.size() < 5 && n < 40) begin
        step();
        n++;
      end
      check_eq("rst_wait_timeout", n >= 40, 0);
    end
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", res_if.out_valid, 0);
    check_eq("mid_rst_data", res_if.out_data, 0);
    check_eq("mid_rst_idx", res_if.out_idx, 0);
    check_eq("mid_rst_last", res_if.out_last, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_err", err, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    in_l2[0] = 16'h3000; in_l2[1] = 16'h3001; in_l2[2] = 16'h3002; in_l2[3] = 16'h3003;
    got_q.delete(); cyc_q.delete();
    start = 1'b1; mode = 2'd1;
    step();
    start = 1'b0;
    step();
    step();
    check_eq("post_rst_idx", res_if.out_idx, 0);
    check_eq("post_rst_data", res_if.out_data, 16'h3000);
    drain(60, 1'b1);
    check_eq("post_rst_count", got_q.size(), 4);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      start = ($urandom_range(0, 5) == 0);
      mode  = 2'($urandom_range(0, 3));
      res_if.out_ready = ($urandom_range(0, 9) < 7);
      rand_inputs();
      step();
    end
    res_if.out_ready = 1'b1;
    drain(100, 1'b1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tree_result_serializer.md
TREE_RESULT_SERIALIZER -- requirements
Module: tree_result_serializer

Interface
REQ-001 SHALL have parameter MAC_BW, default 8; the MAC operand width, so each result word is 2*MAC_BW bits.
REQ-002 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1, capture request, sampled on the rising edge.
REQ-005 SHALL have port mode, input, 2, level select sampled with start: 0=L1 (16 words), 1=L2 (4 words), 2=L3 (1 word), 3=reserved.
REQ-006 SHALL have port in_l1, input, 16 x 2*MAC_BW, adder-tree level-1 outputs.
REQ-007 SHALL have port in_l2, input, 4 x 2*MAC_BW, adder-tree level-2 outputs.
REQ-008 SHALL have port in_l3, input, 2*MAC_BW, adder-tree level-3 output.
REQ-009 SHALL have port out_valid, output, 1, out_data holds a valid word.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts a word.
REQ-011 SHALL have port out_data, output, 2*MAC_BW, the current result word.
REQ-012 SHALL have port out_idx, output, 4, index of the current word within the selected level.
REQ-013 SHALL have port out_last, output, 1, the current word is the final word of the burst.
REQ-014 SHALL have port busy, output, 1, high in every state other than IDLE.
REQ-015 SHALL have port err, output, 1, one-cycle pulse flagging a rejected start.

Function
REQ-016 SHALL implement three states, IDLE, WAIT and SEND, and start in IDLE.
REQ-017 SHALL, when start=1 at edge E0 in IDLE with mode 0/1/2, latch mode, load the wait counter with k=mode+1, and go to WAIT.
- E0 is the edge at which the tree registers its level-1 inputs.
REQ-018 SHALL, in WAIT, decrement the counter each edge and, at edge E0+k, copy the selected level into an internal buffer and go to SEND.
- Capture falls 1, 2 or 3 cycles after E0 for L1, L2 or L3.
REQ-019 SHALL, in SEND, drive out_valid=1, out_data=buffer[idx] and out_idx=idx, with idx starting at 0.
REQ-020 SHALL assert out_last when idx = N-1, where N is 16, 4 or 1 for the selected level.
REQ-021 SHALL count a transfer only at an edge where out_valid and out_ready are both 1.
- On a transfer, idx increments.
- On the transfer of the last word, the block returns to IDLE and out_valid/busy fall after that edge.
REQ-022 SHALL hold out_data, out_idx and out_last stable while out_valid=1 and out_ready=0.
REQ-023 SHALL keep out_valid, out_data, out_idx and out_last at 0 whenever the block is not in SEND.
REQ-024 SHALL NOT produce a bubble between consecutive words when out_ready stays 1.
- L1 with constant out_ready=1 emits 16 words on 16 consecutive cycles.
REQ-025 SHALL transfer words as raw copies, with no arithmetic, truncation or sign change.
REQ-026 SHALL ignore start in WAIT or SEND, pulse err for one cycle, and leave state, buffer and index unchanged.
REQ-027 SHALL ignore start with mode=3 in IDLE, pulse err for one cycle, and remain in IDLE.
REQ-028 SHALL NOT accept a new start in the same cycle as the final transfer, because busy is still 1 then.
- Such a start is rejected per REQ-026.
- The earliest accepted start is the next edge.
REQ-029 SHALL NOT change the buffer after capture until the next accepted start.
- Changes on in_l* during SEND do not reach the output.

Reset
REQ-030 SHALL, when rst_n=0, immediately and asynchronously set:
- the state to IDLE;
- out_valid, out_data, out_idx, out_last, busy and err to 0;
- the counter and idx to 0.
REQ-031 SHALL abort any WAIT or SEND in progress on reset.
- Buffer contents are don't-care.
- No word is emitted after reset release until a new accepted start.
REQ-032 SHALL accept start on the first rising edge after rst_n deasserts.

Verification
REQ-033 SHALL be covered by an L1 burst test.
- Stimulus: MAC_BW=8, in_l1[i]=16'h0100+i, start with mode=0 at E0, out_ready=1.
- Required response: words 0x0100..0x010F appear with idx 0..15 from the cycle after E1, out_last only on 0x010F, and busy low after 16 transfers.
REQ-034 SHALL be covered by a backpressure test.
- Stimulus: mode=1, in_l2={0x0004,0x0003,0x0002,0x0001} (in_l2[0]=0x0001), out_ready toggling 1,0,0,1,...
- Required response: 0x0001,0x0002,0x0003,0x0004 delivered in order, each stable during the ready-low cycles.
REQ-035 SHALL be covered by an L3 latency test.
- Stimulus: mode=2, in_l3=0xBEEF valid from E2.
- Required response: capture at E3, then one word 0xBEEF with idx=0 and out_last=1.
REQ-036 SHALL be covered by a rejected-start test.
- Stimulus: start during SEND, and start with mode=3 in IDLE.
- Required response: err pulses for exactly one cycle each, and the burst continues unchanged.
REQ-037 SHALL be covered by a mid-burst reset test.
- Stimulus: rst_n low after the 5th word of an L1 burst.
- Required response: all outputs 0 immediately, and a new start after release yields a fresh burst from idx 0.
